// File: rtl/wb_defs_pkg.sv
// Shared Wishbone width defaults and arbiter state encodings.
package wb_defs_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request searching upward from last+1 with wrap.
module rr_priority_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]                    req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last_i,
  output logic [N-1:0]                    gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx_o
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int unsigned cand;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % N;
      if (!found && req_i[IDX_W'(cand)]) begin
        found                = 1'b1;
        gnt_o[IDX_W'(cand)]  = 1'b1;
        idx_o                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic slave between NUM_MASTERS masters,
// with a watchdog that errors out cycles the slave never terminates.
module wb_rr_arbiter
  import wb_defs_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = WB_ADDR_W,
  parameter int unsigned DATA_WIDTH  = WB_DATA_W,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [NUM_MASTERS-1:0]                m_rty_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [ADDR_WIDTH-1:0]                 s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  input  logic                                  s_ack_i,
  input  logic                                  s_err_i,
  input  logic                                  s_rty_i,
  output logic [NUM_MASTERS-1:0]                grant_o
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       wd_cnt_q, wd_cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   busy;
  logic                   s_term;
  logic                   wd_fire;

  rr_priority_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_MASTERS - 1);
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // last_q doubles as the owner index while BUSY.
  assign busy    = (state_q == ST_BUSY);
  assign s_term  = s_ack_i | s_err_i | s_rty_i;
  assign wd_fire = busy && (wd_cnt_q == CNT_W'(TIMEOUT));
  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ST_BUSY;
          grant_d = pick_gnt;
          last_d  = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!m_cyc_i[last_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
        if (m_cyc_i[last_q] && s_stb_o && !s_term) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Slave-side mux and termination routing; an ack in the firing cycle suppresses the timeout error.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (busy) begin
      s_cyc_o         = m_cyc_i[last_q];
      s_stb_o         = m_stb_i[last_q] & ~wd_fire;
      s_we_o          = m_we_i[last_q];
      s_adr_o         = m_adr_i[32'(last_q) * ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o         = m_dat_i[32'(last_q) * DATA_WIDTH +: DATA_WIDTH];
      s_sel_o         = m_sel_i[32'(last_q) * SEL_W +: SEL_W];
      m_ack_o[last_q] = s_ack_i;
      m_rty_o[last_q] = s_rty_i;
      m_err_o[last_q] = s_err_i | (wd_fire & ~s_ack_i);
    end
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone B4 classic slave port (the SoC interconnect) between NUM_MASTERS requesters.
- Typical masters: picorv32 instruction port, picorv32 data port, UART debug/boot loader.
- Holds the grant for a whole bus cycle (cyc high) and multiplexes master signals to the slave.
- Includes a bus watchdog: a cycle that is never acknowledged is terminated with an error.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; select width is DATA_WIDTH/8.
- TIMEOUT, 255, strobe cycles without ack/err/rty before the watchdog fires (1..65535).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m_cyc_i  in  NUM_MASTERS  per-master cycle request.
- m_stb_i  in  NUM_MASTERS  per-master strobe.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k occupies slice k.
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte selects.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master error.
- m_rty_o  out  NUM_MASTERS  per-master retry.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_sel_o  out  DATA_WIDTH/8  slave byte selects.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations.
- grant_o  out  NUM_MASTERS  one-hot current grant, for debug/LED.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, grant_o=0, last-granted index = NUM_MASTERS-1 (master 0 has first priority), watchdog counter = 0.
  - All s_* outputs and m_ack_o/m_err_o/m_rty_o = 0.
- IDLE state:
  - Each cycle, if any m_cyc_i is set, select the first requester searching upward from last+1 with wrap-around.
  - Register a one-hot grant, update last, go to BUSY.
  - Grant latency: 1 clock from m_cyc_i rising to grant_o and s_cyc_o.
- BUSY state:
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g] & ~wd_fire.
  - s_we_o, s_adr_o, s_dat_o, s_sel_o are combinational muxes of master g.
  - m_ack_o[g] = s_ack_i, m_rty_o[g] = s_rty_i, m_err_o[g] = s_err_i | wd_fire.
  - Non-granted masters see ack/err/rty = 0 (combinational, zero added latency).
  - The grant is held across multiple strobes while m_cyc_i[g] stays high, which gives locked read-modify-write.
  - When m_cyc_i[g] falls: grant cleared and return to IDLE in the same edge. Re-arbitration then needs one IDLE cycle, so there is a 1-cycle bubble between owners.
- Outputs outside BUSY: s_* outputs are 0 when no grant (slave address/data driven 0).
- m_dat_o = s_dat_i unconditionally.
- Watchdog:
  - Counter increments each BUSY cycle with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - Clears on any termination, or when stb is low.
  - When counter == TIMEOUT, wd_fire is asserted for exactly one cycle; the counter then clears.
  - Counter width is clog2(TIMEOUT+1).
- Simultaneous events:
  - Termination and m_cyc_i[g] falling on the same edge: the termination is still delivered; the grant drops on that edge.
  - s_ack_i and wd_fire in the same cycle: the ack wins, err is not asserted, counter clears.
- A master dropping cyc while not granted has no effect.
- Reset mid-cycle aborts the grant immediately; slave cyc deasserts asynchronously.

Decomposition:
- Shared package/include wb_defs: Wishbone width defaults and state encodings IDLE=1'b0, BUSY=1'b1.
- One sub-module, rr_priority_pick:
  - Combinational; inputs: request vector, last index. Output: one-hot next grant plus encoded index.
  - Reusable by the interrupt controller.

Test Plan:
- Single master: master 1 raises cyc/stb read at 0x1000_0000, slave acks 2 clocks later with 0xDEADBEEF → grant_o=2'b10 one clock after cyc; m_ack_o=2'b10 for one clock; m_dat_o=0xDEADBEEF; master 0 never sees ack.
- Contention: both masters raise cyc on the same edge after reset → master 0 granted first. After it drops cyc, master 1 is granted 2 clocks later (1 bubble). Repeating this yields strict alternation 0,1,0,1.
- Locked cycle: master 0 holds cyc over 3 strobes while master 1 requests → grant_o stays 2'b01 for all 3 acks; master 1 is granted only after master 0 drops cyc.
- Watchdog: TIMEOUT=4, slave never acks → m_err_o[g] pulses exactly once, on the 5th strobe cycle; s_stb_o is low in that cycle; master 1's err stays 0.
- Ack at the timeout boundary: s_ack_i arrives in the cycle the counter reaches TIMEOUT → ack delivered, no err.
- Asynchronous reset: reset pulled low mid-transfer between clock edges → s_cyc_o and grant_o go to 0 immediately. After release, master 0 has priority again.
